// File: rtl/sdram_resp.sv
// Single-bank SDR SDRAM device model: command decode, backing array,
// CAS-latency read pipeline and sticky protocol-violation flag.
module sdram_resp #(
  parameter int unsigned ROW_BITS   = 2,
  parameter int unsigned TRCD       = 2,
  parameter logic [9:0]  RESET_MODE = 10'h030
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cke,
  input  logic        _cs,
  input  logic        _ras,
  input  logic        _cas,
  input  logic        _we,
  input  logic [12:0] A,
  input  logic [1:0]  BA,
  input  logic [3:0]  DQM,
  input  logic [31:0] dq_in,
  output logic [31:0] dq_out,
  output logic        dq_oe,
  output logic [9:0]  mode_reg,
  output logic [15:0] refcnt,
  output logic        err
);

  localparam int unsigned COL_W    = 10;
  localparam int unsigned ADDR_W   = ROW_BITS + COL_W;
  localparam int unsigned DEPTH    = 1 << ADDR_W;
  localparam int unsigned LEN_W    = 11;
  localparam int unsigned RCD_W    = 8;
  localparam int unsigned RCD_LOAD = (TRCD > 0) ? TRCD - 1 : 0;

  typedef enum logic [2:0] {
    CMD_LMR = 3'b000,
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_BST = 3'b110,
    CMD_NOP = 3'b111
  } cmd_e;

  typedef enum logic {IDLE, ROW_OPEN} row_state_e;

  function automatic logic bl_ok(input logic [2:0] code);
    return (code inside {3'b000, 3'b001, 3'b010, 3'b011, 3'b111});
  endfunction

  logic [31:0] mem [DEPTH];

  row_state_e          state, state_nxt;
  logic [ROW_BITS-1:0] row, row_nxt;
  logic [RCD_W-1:0]    rcd_cnt, rcd_nxt;
  logic [9:0]          mode_nxt;
  logic [15:0]         refcnt_nxt;
  logic                err_nxt;

  logic                rd_active, rd_active_nxt, rd_full, rd_full_nxt;
  logic [COL_W-1:0]    rd_col, rd_col_nxt;
  logic [LEN_W-1:0]    rd_left, rd_left_nxt;
  logic                wr_active, wr_active_nxt, wr_full, wr_full_nxt;
  logic [COL_W-1:0]    wr_col, wr_col_nxt;
  logic [LEN_W-1:0]    wr_left, wr_left_nxt;

  logic                p1_vld, p2_vld;
  logic [31:0]         p1_data, p2_data;
  logic [3:0]          dqm_d;

  cmd_e                cmd_c;
  logic                issue_c, wr_en_c, full_page_c, cl3_c, sel_vld_c;
  logic [COL_W-1:0]    issue_col_c, wr_col_c;
  logic [LEN_W-1:0]    burst_len_c;
  logic [31:0]         rd_word_c, sel_data_c, rmask_c;
  logic                unused_ok;

  assign unused_ok = ^A[12:10];
  assign cmd_c     = _cs ? CMD_NOP : cmd_e'({_ras, _cas, _we});
  assign cl3_c     = (mode_reg[6:4] == 3'd3);

  // Burst length from the stored mode; undefined codes behave as length 1.
  always_comb begin
    full_page_c = 1'b0;
    case (mode_reg[2:0])
      3'b001:  burst_len_c = LEN_W'(2);
      3'b010:  burst_len_c = LEN_W'(4);
      3'b011:  burst_len_c = LEN_W'(8);
      3'b111: begin
        burst_len_c = LEN_W'(1024);
        full_page_c = 1'b1;
      end
      default: burst_len_c = LEN_W'(1);
    endcase
  end

  always_comb begin
    state_nxt     = state;
    row_nxt       = row;
    rcd_nxt       = (rcd_cnt != '0) ? rcd_cnt - RCD_W'(1) : rcd_cnt;
    mode_nxt      = mode_reg;
    refcnt_nxt    = refcnt;
    err_nxt       = err;
    rd_active_nxt = rd_active;
    rd_full_nxt   = rd_full;
    rd_col_nxt    = rd_col;
    rd_left_nxt   = rd_left;
    wr_active_nxt = wr_active;
    wr_full_nxt   = wr_full;
    wr_col_nxt    = wr_col;
    wr_left_nxt   = wr_left;
    issue_c       = 1'b0;
    issue_col_c   = rd_col;
    wr_en_c       = 1'b0;
    wr_col_c      = wr_col;

    // Bursts in flight advance unless the command below stops or restarts them.
    if (rd_active) begin
      issue_c    = 1'b1;
      rd_col_nxt = rd_col + COL_W'(1);
      if (!rd_full) begin
        rd_left_nxt = rd_left - LEN_W'(1);
        if (rd_left == LEN_W'(1)) rd_active_nxt = 1'b0;
      end
    end
    if (wr_active) begin
      wr_en_c    = 1'b1;
      wr_col_nxt = wr_col + COL_W'(1);
      if (!wr_full) begin
        wr_left_nxt = wr_left - LEN_W'(1);
        if (wr_left == LEN_W'(1)) wr_active_nxt = 1'b0;
      end
    end

    if (cmd_c != CMD_NOP && BA != 2'b00) begin
      err_nxt = 1'b1;
    end else begin
      case (cmd_c)
        CMD_LMR: begin
          if (state == ROW_OPEN || !(A[6:4] == 3'd2 || A[6:4] == 3'd3)) begin
            err_nxt = 1'b1;
          end else begin
            mode_nxt = A[9:0];
            if (!bl_ok(A[2:0])) err_nxt = 1'b1;
          end
        end
        CMD_REF: begin
          if (state == ROW_OPEN) err_nxt = 1'b1;
          else                   refcnt_nxt = refcnt + 16'd1;
        end
        CMD_PRE: begin
          state_nxt     = IDLE;
          issue_c       = 1'b0;
          rd_active_nxt = 1'b0;
          wr_en_c       = 1'b0;
          wr_active_nxt = 1'b0;
        end
        CMD_ACT: begin
          if (state == ROW_OPEN) begin
            err_nxt = 1'b1;
          end else begin
            state_nxt = ROW_OPEN;
            row_nxt   = A[ROW_BITS-1:0];
            rcd_nxt   = RCD_W'(RCD_LOAD);
          end
        end
        CMD_RD, CMD_WR: begin
          if (state != ROW_OPEN || rcd_cnt != '0) begin
            err_nxt = 1'b1;
          end else if (cmd_c == CMD_RD) begin
            wr_en_c       = 1'b0;
            wr_active_nxt = 1'b0;
            issue_c       = 1'b1;
            issue_col_c   = A[COL_W-1:0];
            rd_col_nxt    = A[COL_W-1:0] + COL_W'(1);
            rd_left_nxt   = burst_len_c - LEN_W'(1);
            rd_full_nxt   = full_page_c;
            rd_active_nxt = full_page_c || (burst_len_c != LEN_W'(1));
          end else begin
            issue_c       = 1'b0;
            rd_active_nxt = 1'b0;
            wr_en_c       = 1'b1;
            wr_col_c      = A[COL_W-1:0];
            wr_col_nxt    = A[COL_W-1:0] + COL_W'(1);
            wr_left_nxt   = burst_len_c - LEN_W'(1);
            wr_full_nxt   = full_page_c;
            wr_active_nxt = !mode_reg[9] && (full_page_c || (burst_len_c != LEN_W'(1)));
          end
        end
        CMD_BST: begin
          issue_c       = 1'b0;
          rd_active_nxt = 1'b0;
          wr_en_c       = 1'b0;
          wr_active_nxt = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Word fetched at issue; CL selects a one- or two-stage delay before dq_out.
  assign rd_word_c  = mem[{row, issue_col_c}];
  assign sel_vld_c  = cl3_c ? p2_vld  : p1_vld;
  assign sel_data_c = cl3_c ? p2_data : p1_data;
  assign rmask_c    = {{8{dqm_d[3]}}, {8{dqm_d[2]}}, {8{dqm_d[1]}}, {8{dqm_d[0]}}};

  always_ff @(posedge clk) begin
    if (cke && wr_en_c) begin
      for (int b = 0; b < 4; b++) begin
        if (!DQM[b]) mem[{row, wr_col_c}][8*b +: 8] <= dq_in[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      row       <= '0;
      rcd_cnt   <= '0;
      mode_reg  <= RESET_MODE;
      refcnt    <= '0;
      err       <= 1'b0;
      rd_active <= 1'b0;
      rd_full   <= 1'b0;
      rd_col    <= '0;
      rd_left   <= '0;
      wr_active <= 1'b0;
      wr_full   <= 1'b0;
      wr_col    <= '0;
      wr_left   <= '0;
      p1_vld    <= 1'b0;
      p1_data   <= '0;
      p2_vld    <= 1'b0;
      p2_data   <= '0;
      dqm_d     <= '0;
      dq_oe     <= 1'b0;
      dq_out    <= '0;
    end else if (cke) begin
      state     <= state_nxt;
      row       <= row_nxt;
      rcd_cnt   <= rcd_nxt;
      mode_reg  <= mode_nxt;
      refcnt    <= refcnt_nxt;
      err       <= err_nxt;
      rd_active <= rd_active_nxt;
      rd_full   <= rd_full_nxt;
      rd_col    <= rd_col_nxt;
      rd_left   <= rd_left_nxt;
      wr_active <= wr_active_nxt;
      wr_full   <= wr_full_nxt;
      wr_col    <= wr_col_nxt;
      wr_left   <= wr_left_nxt;
      p1_vld    <= issue_c;
      p1_data   <= rd_word_c;
      p2_vld    <= p1_vld;
      p2_data   <= p1_data;
      dqm_d     <= DQM;
      dq_oe     <= sel_vld_c;
      dq_out    <= sel_vld_c ? (sel_data_c & ~rmask_c) : '0;
    end
  end

endmodule

// File: tb/tb_sdram_resp.sv
// Scoreboard bench for sdram_resp: expected read words are queued with the
// active clock edge at which they must be valid on DQ.
module tb_sdram_resp;

  localparam logic [2:0] C_LMR = 3'b000;
  localparam logic [2:0] C_REF = 3'b001;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_BST = 3'b110;
  localparam logic [2:0] C_NOP = 3'b111;

  typedef struct {
    int          edge_no;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, cke, cs_n, ras_n, cas_n, we_n;
  logic [12:0] a;
  logic [1:0]  ba;
  logic [3:0]  dqm;
  logic [31:0] dq_in, dq_out;
  logic        dq_oe, err;
  logic [9:0]  mode_reg;
  logic [15:0] refcnt;

  exp_t        sb[$];
  logic [31:0] mdl [int];
  int          acyc   = 0;
  int          n_vec  = 0;
  int          n_miss = 0;

  sdram_resp dut (
    .clk(clk), .reset(rst_n), .cke(cke),
    ._cs(cs_n), ._ras(ras_n), ._cas(cas_n), ._we(we_n),
    .A(a), .BA(ba), .DQM(dqm), .dq_in(dq_in),
    .dq_out(dq_out), .dq_oe(dq_oe), .mode_reg(mode_reg),
    .refcnt(refcnt), .err(err)
  );

  always #5 clk = ~clk;

  // Active edges only: cke=0 edges do not advance the device.
  always @(posedge clk) if (cke) acyc <= acyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Output seen here is what the device presents across the next active edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && cke) begin
      if (sb.size() != 0 && sb[0].edge_no == acyc + 1) begin
        e = sb.pop_front();
        chk("rd_oe", 32'(dq_oe), 32'd1);
        chk("rd_data", dq_out, e.data);
      end else begin
        chk("idle_oe", 32'(dq_oe), 32'd0);
      end
    end
  end

  task automatic drive(input logic [2:0] op, input logic [12:0] addr, input logic [1:0] bank,
                       input logic [3:0] m, input logic [31:0] d, output int n);
    cs_n = (op == C_NOP);
    {ras_n, cas_n, we_n} = op;
    a = addr; ba = bank; dqm = m; dq_in = d;
    n = acyc + 1;
    @(posedge clk); #1;
  endtask

  task automatic cmd(input logic [2:0] op, input logic [12:0] addr);
    int n;
    drive(op, addr, 2'b00, 4'h0, 32'h0, n);
  endtask

  task automatic nop(input int k);
    for (int i = 0; i < k; i++) cmd(C_NOP, 13'h0);
  endtask

  task automatic wr1(input int col, input logic [31:0] d, input logic [3:0] m);
    int n;
    logic [31:0] w;
    drive(C_WR, 13'(col), 2'b00, m, d, n);
    w = mdl.exists(col) ? mdl[col] : 32'h0;
    for (int b = 0; b < 4; b++) if (!m[b]) w[8*b +: 8] = d[8*b +: 8];
    mdl[col] = w;
  endtask

  task automatic rd(input int col, input int words, input int cl);
    int n;
    exp_t e;
    drive(C_RD, 13'(col), 2'b00, 4'h0, 32'h0, n);
    for (int k = 0; k < words; k++) begin
      e.edge_no = n + cl + k;
      e.data    = mdl[(col + k) % 1024];
      sb.push_back(e);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    cmd(C_NOP, 13'h0);
    cmd(C_NOP, 13'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; cke = 1'b1;
    cs_n = 1'b1; {ras_n, cas_n, we_n} = C_NOP;
    a = '0; ba = '0; dqm = '0; dq_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_oe", 32'(dq_oe), 32'd0);
    chk("rst_dq", dq_out, 32'd0);
    chk("rst_mode", 32'(mode_reg), 32'h030);
    chk("rst_ref", 32'(refcnt), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;

    // CL3, BL1, single-location writes; byte-masked write then read-back.
    cmd(C_LMR, 13'b0_0010_0011_0000);
    chk("lmr_single", 32'(mode_reg), 32'h230);
    cmd(C_ACT, 13'h0);
    nop(2);
    for (int c = 0; c < 12; c++)    wr1(c, 32'hC0DE_0000 | c, 4'h0);
    for (int c = 100; c < 108; c++) wr1(c, 32'hC0DE_0000 | c, 4'h0);
    wr1(1022, 32'hC0DE_03FE, 4'h0);
    wr1(1023, 32'hC0DE_03FF, 4'h0);
    wr1(5, 32'h0, 4'h0);
    wr1(5, 32'hAABB_CCDD, 4'b0011);
    rd(5, 1, 3);
    nop(5);
    rd(9, 1, 3);
    nop(5);
    chk("err_clean1", 32'(err), 32'd0);

    // Full page from col 1022 wraps, terminated after four words.
    cmd(C_PRE, 13'h0);
    cmd(C_LMR, 13'b0_0000_0011_0111);
    chk("lmr_fullpg", 32'(mode_reg), 32'h037);
    cmd(C_ACT, 13'h0);
    nop(1);
    rd(1022, 4, 3);
    nop(3);
    cmd(C_BST, 13'h0);
    nop(6);

    // Clock-enable freeze mid full-page burst; stray READ while frozen is ignored.
    rd(0, 6, 3);
    nop(2);
    cke = 1'b0;
    for (int i = 0; i < 4; i++) drive(C_RD, 13'd2, 2'b00, 4'h0, 32'h0, n);
    cke = 1'b1;
    nop(3);
    cmd(C_BST, 13'h0);
    nop(6);
    chk("err_clean2", 32'(err), 32'd0);

    // CL2, BL4, burst writes; DQM on the cycle after READ masks word 1.
    cmd(C_PRE, 13'h0);
    cmd(C_LMR, 13'b0_0000_0010_0010);
    chk("lmr_cl2", 32'(mode_reg), 32'h022);
    cmd(C_ACT, 13'h0);
    nop(1);
    rd(8, 4, 2);
    sb[sb.size() - 3].data = sb[sb.size() - 3].data & 32'h0000_FFFF;
    drive(C_NOP, 13'h0, 2'b00, 4'b1100, 32'h0, n);
    nop(6);
    drive(C_WR, 13'd100, 2'b00, 4'h0, 32'hB0B0_0000, n);
    for (int i = 1; i < 5; i++) drive(C_NOP, 13'h0, 2'b00, 4'h0, 32'hB0B0_0000 | i, n);
    for (int i = 0; i < 4; i++) mdl[100 + i] = 32'hB0B0_0000 | i;
    nop(1);
    rd(100, 4, 2);
    nop(5);
    rd(104, 4, 2);
    nop(6);
    chk("err_clean3", 32'(err), 32'd0);

    // Protocol errors: each sets err and has no effect.
    do_reset();
    chk("err_pre_a", 32'(err), 32'd0);
    cmd(C_RD, 13'd5);
    nop(4);
    chk("err_rd_idle", 32'(err), 32'd1);

    do_reset();
    cmd(C_ACT, 13'h0);
    cmd(C_RD, 13'd5);
    nop(4);
    chk("err_trcd", 32'(err), 32'd1);

    do_reset();
    cmd(C_ACT, 13'h0);
    nop(1);
    chk("err_pre_c", 32'(err), 32'd0);
    cmd(C_ACT, 13'h1);
    chk("err_act_open", 32'(err), 32'd1);
    nop(1);
    rd(5, 1, 3);
    nop(5);

    do_reset();
    drive(C_LMR, 13'b0_0000_0010_0010, 2'b01, 4'h0, 32'h0, n);
    chk("err_ba", 32'(err), 32'd1);
    chk("ba_mode_kept", 32'(mode_reg), 32'h030);

    do_reset();
    for (int i = 0; i < 3; i++) cmd(C_REF, 13'h0);
    chk("refcnt3", 32'(refcnt), 32'd3);
    chk("err_ref_ok", 32'(err), 32'd0);
    cmd(C_LMR, 13'b0_0000_0101_0000);
    chk("err_bad_cl", 32'(err), 32'd1);
    chk("cl_mode_kept", 32'(mode_reg), 32'h030);

    // Reset in the middle of a full-page read burst.
    do_reset();
    cmd(C_LMR, 13'b0_0000_0011_0111);
    cmd(C_ACT, 13'h0);
    nop(1);
    rd(0, 2, 3);
    nop(4);
    chk("oe_before_rst", 32'(dq_oe), 32'd1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("rst_async_oe", 32'(dq_oe), 32'd0);
    chk("rst_async_dq", dq_out, 32'd0);
    chk("rst_async_mode", 32'(mode_reg), 32'h030);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cmd(C_ACT, 13'h0);
    nop(2);
    rd(5, 1, 3);
    nop(6);

    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/sdram_resp.md
Name: sdram_resp

Overview:
- Synthesizable single-bank SDRAM responder, the device end of the SDRAM command interface.
- Decodes CS/RAS/CAS/WE/A/BA/DQM exactly as an SDR SDRAM does and services reads and writes from an internal array. Read data is returned with programmable CAS latency.
- Used as an on-FPGA loopback target and as a checker for the SDRAM controller's command legality and timing; it flags illegal sequences.
- The 32-bit DQ spans two 16-bit devices: DQM[1:0] covers the low half, DQM[3:2] the high half.

Parameters:
- ROW_BITS, 2, implemented row address bits; the array holds 2^ROW_BITS x 1024 x 32 bits. Upper row bits are ignored.
- TRCD, 2, minimum cycles from ACTIVE to READ/WRITE.
- RESET_MODE, 10'h030, mode register value after reset (CL3, BL1, burst write).

Ports:
- clk  in  1  SDRAM clock; all sampling on posedge.
- reset  in  1  asynchronous, active-low reset.
- cke  in  1  clock enable; 0 freezes all internal state.
- _cs  in  1  chip select, active low.
- _ras  in  1  row strobe, active low.
- _cas  in  1  column strobe, active low.
- _we  in  1  write enable, active low.
- A  in  13  address / mode register value.
- BA  in  2  bank address; must be 0.
- DQM  in  4  byte masks.
- dq_in  in  32  write data.
- dq_out  out  32  read data.
- dq_oe  out  1  responder is driving DQ.
- mode_reg  out  10  current mode register.
- refcnt  out  16  count of AUTO_REFRESH commands.
- err  out  1  sticky protocol error flag.

Behaviour:
- Reset values (reset=0, asynchronous): dq_out=0, dq_oe=0, mode_reg=RESET_MODE, refcnt=0, err=0, no row open, burst idle, read pipeline flushed.
- A reset mid-burst aborts the burst immediately; array contents are not cleared.

Command decode:
- Commands are decoded at posedge with cke=1.
- _cs=1 is deselect and is treated as NOP.
- {_ras,_cas,_we} decoding:
  - 000 LOAD_MODE_REG
  - 001 AUTO_REFRESH
  - 010 PRECHARGE
  - 011 ACTIVE
  - 100 WRITE
  - 101 READ
  - 110 BURST_TERMINATE
  - 111 NOP
- BA != 0 on any command: err=1 and the command is ignored.

Mode register fields:
- A[2:0] burst length: 000=1, 001=2, 010=4, 011=8, 111=full page (1024). Other codes set err and are treated as 1.
- A[6:4] CAS latency: only 2 and 3 are legal. Others set err; mode_reg is not updated.
- A[9]: 1 = single-location writes, 0 = writes burst at the programmed length.

Row state (IDLE / ROW_OPEN):
- ACTIVE in IDLE: latch the row from A, move to ROW_OPEN, start the tRCD counter.
- ACTIVE in ROW_OPEN: err, ignored.
- PRECHARGE (any A10): move to IDLE and terminate any burst.
- LOAD_MODE_REG or AUTO_REFRESH in ROW_OPEN: err, ignored.
- AUTO_REFRESH in IDLE: refcnt increments and wraps at 16'hFFFF->0.
- READ/WRITE in IDLE, or fewer than TRCD cycles after ACTIVE: err, ignored.

Read path:
- READ at edge n loads the burst column from A[9:0].
- Words advance one per cycle; the column wraps 1023->0 within the row; a full-page burst continues until terminated.
- Data is pipelined so dq_oe=1 and dq_out=word k are stable across edge n+CL+k.
- DQM read latency is 2: bytes whose DQM was high at edge e are forced to 0 in the word valid at edge e+2.
- BURST_TERMINATE or PRECHARGE at edge m: the last valid word is the one at edge m+CL-1; dq_oe falls after that.
- A new READ during a burst restarts the burst at the new column, with the same latency rule.
- WRITE during a read burst: the read terminates as for BURST_TERMINATE at the WRITE edge.

Write path:
- WRITE at edge n stores dq_in to {row, A[9:0]} at that edge. Each byte is written only where its DQM bit is 0 (zero latency).
- In burst-write mode, subsequent cycles write dq_in at column+1 and onward until the length is reached or the burst is terminated.
- dq_oe is 0 during writes.

Simultaneous / boundary cases:
- cke=0: the command is ignored and all counters, pipeline and outputs hold.
- A read and a write to the same word never coincide because the responder is single-port.
- err stays set until reset.

Test Plan:
- Reset, then LOAD_MODE_REG A=10'b1000110000, ACTIVE row 0, 2 NOPs, WRITE col 5 dq_in=32'hAABBCCDD with DQM=4'b0011 -> only bytes [31:16] are written. Read-back at CL3 gives 32'hAABB0000, valid at READ edge+3.
- LOAD_MODE_REG A=10'b0000110111 (CL3, full page), ACTIVE, READ col 1022 -> words from cols 1022, 1023, 0, 1 on consecutive edges starting at +3. BURST_TERMINATE at edge m -> dq_oe low after edge m+2.
- Mode CL2 (A[6:4]=010), BL4, READ col 8 -> 4 words valid at edges n+2..n+5; dq_oe=0 at n+6.
- Error cases each set err=1 and the command has no effect:
  - READ with no row open.
  - READ 1 cycle after ACTIVE.
  - ACTIVE while a row is open.
  - BA=2'b01.
- Three AUTO_REFRESH commands in IDLE -> refcnt=3. cke=0 held for 4 cycles mid full-page burst -> the burst resumes from the same word afterwards.
- reset asserted mid-burst -> dq_oe=0 immediately, mode_reg=10'h030. Array data written earlier is still readable after re-initialization.
